shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; 32 is the only supported value, and the shift amount is 5 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  unit accepts a request this cycle.
REQ-006 op  input  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-007 in  input  32  operand.
REQ-008 sha  input  5  shift amount, 0..31.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out  output  32  shifted result.
REQ-012 carry  output  1  last bit shifted out (ROR: the new out[31] for a right rotate).
REQ-013 zero  output  1  out == 0.
REQ-014 sign  output  1  out[31].

Function
REQ-015 Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 Pipeline: two stages.
- S1 registers op/in/sha.
- S2 registers out/carry/zero/sign, computed combinationally from S1.
REQ-017 Latency: a request accepted at edge N presents out_valid at edge N+2 when there is no backpressure.
REQ-018 Throughput: one result per cycle when out_ready is held high.
REQ-019 Stall rules:
- S2 holds when out_valid && !out_ready.
- S1 advances into S2 when S2 is empty or transferring.
- in_ready = !S1_valid || S1 advancing.
REQ-020 No loss, no reorder: while stalled, at most two requests are held in flight; none is dropped, duplicated or reordered.
REQ-021 Result stability: out, carry, zero and sign hold their value while out_valid && !out_ready.
REQ-022 SLL: zero-fill from bit 0.
REQ-023 SRL: zero-fill from bit 31.
REQ-024 SRA: fill with in[31].
REQ-025 ROR: bits leaving bit 0 re-enter at bit 31.
REQ-026 Carry for sha != 0:
- SLL: in[32-sha].
- SRL/SRA: in[sha-1].
- ROR: in[sha-1].
REQ-027 sha == 0 gives out = in and carry = 0 for every op.
REQ-028 SRA with a negative operand and sha = 31 gives 0xFFFFFFFF.
REQ-029 SRL with sha = 31 gives out = in[31].
REQ-030 Simultaneous accept and output transfer in the same cycle with a full pipeline sustains throughput with no bubble.
REQ-031 Values of out/carry/zero/sign while out_valid = 0 are don't-care; verification shall not check them.

Reset
REQ-032 While rst_n = 0 at a clock edge, S1_valid and S2_valid clear.
REQ-033 Reset values of registered outputs: out_valid = 0, out = 0, carry = 0, zero = 1, sign = 0.
REQ-034 Reset has priority over any concurrent transfer.
- In-flight requests are discarded.
- in_ready = 1 in the first cycle after reset release.

Structure
REQ-035 Shared package shift_pkg holds:
- the op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ROR);
- WIDTH;
- the shift-amount width 5.
REQ-036 The datapath lives in one combinational sub-module, shift_core: a 5-level log barrel (1/2/4/8/16) with per-level fill select, plus carry extraction.
REQ-037 shift_unit contains only the pipeline registers, valid/ready control and flag generation.

Verification
REQ-038 SRA, in = 0x80000000, sha = 4, out_ready = 1 -> two cycles later out = 0xF8000000, carry = 0, sign = 1, zero = 0.
REQ-039 SRL, in = 0x80000001, sha = 1 -> out = 0x40000000, carry = 1. SLL, in = 0x00000001, sha = 31 -> out = 0x80000000, carry = 0, sign = 1.
REQ-040 ROR, in = 0x00000001, sha = 1 -> out = 0x80000000, carry = 1. SRL, in = 0x0000000F, sha = 4 -> out = 0, zero = 1, carry = 1.
REQ-041 Backpressure, five back-to-back requests with out_ready = 0 for 4 cycles:
- in_ready falls after 2 accepts.
- out is stable while held.
- All five results emerge in order after out_ready = 1.
REQ-042 sha = 0 on every op with in = 0xDEADBEEF -> out = 0xDEADBEEF, carry = 0. Random op/in/sha against a reference model for 10k transfers, with random out_ready -> zero mismatches.
REQ-043 rst_n = 0 asserted for one cycle with two requests in flight:
- The next cycle shows out_valid = 0 and in_ready = 1.
- No stale result appears afterwards.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit: operand width, shift-amount width
// and the operation encoding used on the request port.
package shift_pkg;

    localparam int WIDTH = 32;
    localparam int SHA_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shift_if.sv
// Request/response bundle for the shift unit.
//   request : in_valid, in_ready, op, in, sha
//   response: out_valid, out_ready, out, carry, zero, sign
// master = the side that issues requests and consumes results,
// slave  = the shift unit itself.
interface shift_if;
    import shift_pkg::*;

    logic              in_valid;
    logic              in_ready;
    shift_op_e         op;
    logic [WIDTH-1:0]  in;
    logic [SHA_W-1:0]  sha;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out;
    logic              carry;
    logic              zero;
    logic              sign;

    modport master (
        output in_valid, op, in, sha, out_ready,
        input  in_ready, out_valid, out, carry, zero, sign
    );

    modport slave (
        input  in_valid, op, in, sha, out_ready,
        output in_ready, out_valid, out, carry, zero, sign
    );

endinterface

// File: rtl/shift_core.sv
// Combinational 5-level logarithmic barrel shifter.
//   op    : shift type (SLL/SRL/SRA/ROR)
//   in    : operand
//   sha   : shift amount 0..31
//   out   : shifted result
//   carry : last bit shifted out (for ROR, the bit that lands in out[31])
// Each level shifts by 1/2/4/8/16 when its sha bit is set. Right shifts pick
// their fill per level: zeros (SRL), the sign bit (SRA) or the bits that fell
// off the bottom (ROR).
module shift_core
    import shift_pkg::*;
(
    input  shift_op_e         op,
    input  logic [WIDTH-1:0]  in,
    input  logic [SHA_W-1:0]  sha,
    output logic [WIDTH-1:0]  out,
    output logic              carry
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] fill_mask;
    int               amt;
    logic [SHA_W-1:0] sll_idx;
    logic [SHA_W-1:0] sr_idx;

    always_comb begin
        // NOTE: combinational temporaries get a value on every path before
        // any conditional logic, otherwise synthesis infers latches.
        x         = in;
        fill      = '0;
        fill_mask = '0;
        amt       = 0;
        for (int k = 0; k < SHA_W; k++) begin
            if (sha[k]) begin
                amt       = 1 << k;
                // Upper 'amt' bits are the ones a right shift vacates.
                fill_mask = ~({WIDTH{1'b1}} >> amt);
                unique case (op)
                    OP_SRA:  fill = {WIDTH{x[WIDTH-1]}};
                    OP_ROR:  fill = x << (WIDTH - amt);
                    default: fill = '0;
                endcase
                // NOTE: blocking '=' here is deliberate: each level must see
                // the previous level's result within the same evaluation.
                if (op == OP_SLL) begin
                    x = x << amt;
                end else begin
                    x = (x >> amt) | (fill & fill_mask);
                end
            end
        end
        out = x;
    end

    always_comb begin
        // 32 - sha taken modulo 32; exact for sha in 1..31.
        sll_idx = SHA_W'(WIDTH) - sha;
        sr_idx  = sha - SHA_W'(1);
        carry   = 1'b0;
        if (sha != '0) begin
            if (op == OP_SLL) begin
                carry = in[sll_idx];
            end else begin
                carry = in[sr_idx];
            end
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Two-stage pipelined shift unit with valid/ready flow control.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : shift_if.slave (request in, result out with carry/zero/sign)
// S1 captures the request; S2 captures the barrel-shifter result and flags.
// S2 holds while its result is valid and not taken; S1 advances whenever S2
// is empty or emptying, so a full pipeline streams one result per cycle.
module shift_unit #(
    parameter int WIDTH = shift_pkg::WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    shift_if.slave bus
);
    import shift_pkg::*;

    // Stage 1: registered request
    logic              s1_valid;
    shift_op_e         s1_op;
    logic [WIDTH-1:0]  s1_in;
    logic [SHA_W-1:0]  s1_sha;

    // Stage 2: registered result
    logic              s2_valid;
    logic [WIDTH-1:0]  s2_out;
    logic              s2_carry;
    logic              s2_zero;
    logic              s2_sign;

    logic [WIDTH-1:0]  core_out;
    logic              core_carry;

    logic              s2_free;
    logic              s1_adv;
    logic              in_ready;
    logic              in_fire;

    assign s2_free  = !s2_valid || bus.out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = bus.in_valid && in_ready;

    shift_core u_core (
        .op    (s1_op),
        .in    (s1_in),
        .sha   (s1_sha),
        .out   (core_out),
        .carry (core_carry)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed when the
    // matching valid bit is set, and skipping the reset keeps them plain flops.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_op  <= bus.op;
            s1_in  <= bus.in;
            s1_sha <= bus.sha;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_out   <= '0;
            s2_carry <= 1'b0;
            s2_zero  <= 1'b1;
            s2_sign  <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_out   <= core_out;
                s2_carry <= core_carry;
                s2_zero  <= (core_out == '0);
                s2_sign  <= core_out[WIDTH-1];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out       = s2_out;
    assign bus.carry     = s2_carry;
    assign bus.zero      = s2_zero;
    assign bus.sign      = s2_sign;

endmodule

// File: tb/tb_shift_unit.sv
// Directed and randomized checks for shift_unit. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_shift_unit;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    shift_if bus ();

    shift_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bitwise reference: {carry, out}
    function automatic logic [32:0] model(input shift_op_e op, input logic [31:0] a, input logic [4:0] s);
        logic [31:0] r;
        logic        c;
        int          si;
        si = int'(s);
        for (int i = 0; i < 32; i++) begin
            case (op)
                OP_SLL:  r[i] = (i >= si) ? a[i - si] : 1'b0;
                OP_SRL:  r[i] = (i + si <= 31) ? a[i + si] : 1'b0;
                OP_SRA:  r[i] = (i + si <= 31) ? a[i + si] : a[31];
                default: r[i] = a[(i + si) % 32];
            endcase
        end
        if (si == 0)           c = 1'b0;
        else if (op == OP_SLL) c = a[32 - si];
        else                   c = a[si - 1];
        return {c, r};
    endfunction

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input shift_op_e op, input logic [31:0] a, input logic [4:0] s);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.in       = a;
        bus.sha      = s;
    endtask

    // One isolated request; result checked two edges after it is offered.
    task automatic run_vec(input string tag, input shift_op_e op, input logic [31:0] a,
                           input logic [4:0] s, input logic [31:0] eo, input logic ec);
        @(negedge clk);
        drive(op, a, s);
        bus.out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_out"},   bus.out,            eo);
        check({tag, "_carry"}, 32'(bus.carry),     32'(ec));
        check({tag, "_zero"},  32'(bus.zero),      32'(eo == 32'd0));
        check({tag, "_sign"},  32'(bus.sign),      32'(eo[31]));
    endtask

    shift_op_e   v_op  [5] = '{OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_SRL};
    logic [31:0] v_in  [5] = '{32'h0000_00FF, 32'hF800_0000, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000};
    logic [4:0]  v_sha [5] = '{5'd8, 5'd28, 5'd31, 5'd4, 5'd31};
    logic [31:0] v_out [5] = '{32'h0000_FF00, 32'h0000_000F, 32'hFFFF_FFFF, 32'h8123_4567, 32'h0000_0001};
    logic        v_c   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic [32:0] q[$];
    logic [32:0] e;
    int          sent;
    int          got;
    int          cyc;
    localparam int N_RAND = 10000;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = OP_SLL;
        bus.in        = '0;
        bus.sha       = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out",       bus.out,            32'd0);
        check("rst_carry",     32'(bus.carry),     32'd0);
        check("rst_zero",      32'(bus.zero),      32'd1);
        check("rst_sign",      32'(bus.sign),      32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed vectors with hand-computed results
        run_vec("sra_neg4",  OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
        run_vec("srl_1",     OP_SRL, 32'h8000_0001, 5'd1,  32'h4000_0000, 1'b1);
        run_vec("sll_31",    OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
        run_vec("ror_1",     OP_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1);
        run_vec("srl_zero",  OP_SRL, 32'h0000_000F, 5'd4,  32'h0000_0000, 1'b1);
        run_vec("sll_msbc",  OP_SLL, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1);
        run_vec("sra_pos31", OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1);
        run_vec("sra_neg31", OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
        run_vec("srl_31",    OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
        run_vec("ror_16",    OP_ROR, 32'h1234_5678, 5'd16, 32'h5678_1234, 1'b0);
        run_vec("sll_sha0",  OP_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        run_vec("srl_sha0",  OP_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        run_vec("sra_sha0",  OP_SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        run_vec("ror_sha0",  OP_ROR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        idle(2);

        // Streaming: one accept and one result every cycle, no bubble
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (k < 4) drive(v_op[k], v_in[k], v_sha[k]);
            else       bus.in_valid = 1'b0;
            #1;
            if (k < 4) check($sformatf("stream_in_ready_%0d", k), 32'(bus.in_ready), 32'd1);
            if (k >= 2) begin
                check($sformatf("stream_valid_%0d", k), 32'(bus.out_valid), 32'd1);
                check($sformatf("stream_out_%0d", k),   bus.out,            v_out[k-2]);
            end
        end
        idle(3);

        // Backpressure: five back-to-back requests, out_ready low for 4 cycles
        sent = 0;
        got  = 0;
        for (cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 4);
            if (sent < 5) drive(v_op[sent], v_in[sent], v_sha[sent]);
            else          bus.in_valid = 1'b0;
            #1;
            if (cyc == 2) begin
                check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check("bp_accepts",      32'(sent),         32'd2);
            end
            if (cyc == 2 || cyc == 3) begin
                check($sformatf("bp_hold_valid_%0d", cyc), 32'(bus.out_valid), 32'd1);
                check($sformatf("bp_hold_out_%0d", cyc),   bus.out,            v_out[0]);
                check($sformatf("bp_hold_carry_%0d", cyc), 32'(bus.carry),     32'(v_c[0]));
            end
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("bp_out_%0d", got),   bus.out,        v_out[got]);
                check($sformatf("bp_carry_%0d", got), 32'(bus.carry), 32'(v_c[got]));
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        check("bp_count", 32'(got), 32'd5);
        idle(3);

        // Reset with two requests in flight and a request offered during reset
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(OP_SLL, 32'h0000_0003, 5'd1);
        @(negedge clk);
        drive(OP_SRL, 32'hFFFF_0000, 5'd8);
        @(negedge clk);
        rst_n = 1'b0;
        drive(OP_ROR, 32'hAAAA_5555, 5'd3);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_rst_no_stale_%0d", k), 32'(bus.out_valid), 32'd0);
        end

        // Random traffic against the bitwise model, random backpressure
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < N_RAND && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            bus.in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
            bus.op        = shift_op_e'($urandom_range(0, 3));
            bus.in        = $urandom();
            bus.sha       = 5'($urandom_range(0, 31));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_result", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("rand_out",   bus.out,        e[31:0]);
                    check("rand_carry", 32'(bus.carry), 32'(e[32]));
                    check("rand_zero",  32'(bus.zero),  32'(e[31:0] == 32'd0));
                    check("rand_sign",  32'(bus.sign),  32'(e[31]));
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.op, bus.in, bus.sha));
                sent++;
            end
        end
        check("rand_count", 32'(got), 32'(N_RAND));
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
